// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_pkg
//  Description : Shared encodings for the multicycle control unit: FSM states,
//                instruction opcodes, datapath mux selects and trap causes.
//  Revision    : 1.0  initial release
// ============================================================================
package control_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11,
      S_TRAP      = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
   localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
   localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SOURCE_ALU    = 2'b00;
   localparam logic [1:0] PC_SOURCE_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SOURCE_JUMP   = 2'b10;

   localparam logic [1:0] TRAP_NONE    = 2'b00;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
   localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

   // States that own the memory port and may stall on mem_ready
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_outputs_dec.sv
`default_nettype none
// ============================================================================
//  Module      : control_outputs_dec
//  Description : Combinational state-to-strobe decoder. Only the FETCH
//                load enables depend on mem_ready; reset blanks everything.
//  Revision    : 1.0  initial release
// ============================================================================
module control_outputs_dec
   import control_pkg::*;
(
   input  logic       reset,
   input  state_t     state,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       halted,
   output logic [3:0] state_o
);

   // Moore decode of the current state; reset forces every strobe low so an
   // aborted instruction never writes anything
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALU_SRC_B_REG;
      alu_op        = ALU_OP_ADD;
      pc_source     = PC_SOURCE_ALU;
      halted        = 1'b0;
      state_o       = 4'd0;
      if (!reset) begin
         state_o = state;
         case (state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = ALU_SRC_B_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = ALU_SRC_B_IMM_SH2;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = ALU_SRC_B_IMM;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_OP_FUNCT;
            end
            S_ALU_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = ALU_OP_SUB;
               pc_write_cond = 1'b1;
               pc_source     = PC_SOURCE_ALUOUT;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = PC_SOURCE_JUMP;
            end
            S_ADDI_WB: begin
               reg_write = 1'b1;
            end
            S_TRAP: begin
               halted = 1'b1;
            end
            default: begin
               halted = 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : control_multiciclo
//  Description : Multicycle control FSM for the shared-memory datapath, with
//                memory wait-state timeout, illegal-opcode trap and a
//                retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module control_multiciclo
   import control_pkg::*;
#(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             halted,
   output logic [1:0]       trap_cause,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [7:0] c_wait_last = 8'(WAIT_LIMIT - 1);

   state_t           r_state;
   logic [7:0]       r_wait_cnt;
   logic [CNT_W-1:0] r_instr_count;
   logic [1:0]       r_trap_cause;
   logic             w_wait_expired;
   logic             w_zero_unused;

   // zero is consumed by the datapath through pc_write_cond, not by the FSM
   assign w_zero_unused  = zero;
   assign w_wait_expired = !mem_ready && (r_wait_cnt == c_wait_last);

   // State sequencing, wait-state timeout and retire counting
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_FETCH;
         r_wait_cnt    <= '0;
         r_instr_count <= '0;
         r_trap_cause  <= TRAP_NONE;
      end else begin
         if (is_mem_state(r_state) && !mem_ready && !w_wait_expired)
            r_wait_cnt <= r_wait_cnt + 8'd1;
         else
            r_wait_cnt <= '0;

         case (r_state)
            S_FETCH: begin
               if (mem_ready) begin
                  r_state <= S_DECODE;
               end else if (w_wait_expired) begin
                  r_state      <= S_TRAP;
                  r_trap_cause <= TRAP_TIMEOUT;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                  OP_RTYPE:     r_state <= S_EXECUTE;
                  OP_BEQ:       r_state <= S_BRANCH;
                  OP_J:         r_state <= S_JUMP;
                  OP_ADDI:      r_state <= S_ADDI_EXEC;
                  default: begin
                     r_state      <= S_TRAP;
                     r_trap_cause <= TRAP_ILLEGAL;
                  end
               endcase
            end
            S_MEM_ADDR: begin
               r_state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
               if (mem_ready) begin
                  r_state <= S_MEM_WB;
               end else if (w_wait_expired) begin
                  r_state      <= S_TRAP;
                  r_trap_cause <= TRAP_TIMEOUT;
               end
            end
            S_MEM_WRITE: begin
               if (mem_ready) begin
                  r_state       <= S_FETCH;
                  r_instr_count <= r_instr_count + CNT_W'(1);
               end else if (w_wait_expired) begin
                  r_state      <= S_TRAP;
                  r_trap_cause <= TRAP_TIMEOUT;
               end
            end
            S_EXECUTE:   r_state <= S_ALU_WB;
            S_ADDI_EXEC: r_state <= S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
               r_state       <= S_FETCH;
               r_instr_count <= r_instr_count + CNT_W'(1);
            end
            S_TRAP:  r_state <= S_TRAP;
            default: r_state <= S_TRAP;
         endcase
      end
   end

   assign trap_cause  = r_trap_cause;
   assign instr_count = r_instr_count;

   control_outputs_dec u_dec (
      .reset         (reset),
      .state         (r_state),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .halted        (halted),
      .state_o       (state_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_multiciclo
//  Description : Directed cycle-by-cycle bench for control_multiciclo. The
//                stimulus process queues the expected outputs of every cycle;
//                a monitor compares them on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_multiciclo;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic        halted;
   logic [1:0]  trap_cause;
   logic [3:0]  state_o;
   logic [31:0] instr_count;

   typedef struct {
      int          id;
      logic [3:0]  st;
      logic [15:0] stb;
      logic        hlt;
      logic [1:0]  tc;
      logic [31:0] cnt;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          checks;
   int          errors;
   int          step_id;
   logic [1:0]  exp_tc;
   logic [31:0] exp_cnt;
   logic [15:0] act_stb;

   control_multiciclo #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .halted        (halted),
      .trap_cause    (trap_cause),
      .state_o       (state_o),
      .instr_count   (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe bit order: pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
   // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
   // alu_op[1:0], pc_source[1:0]
   assign act_stb = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

   // Hand-written strobe words for each state
   function automatic logic [15:0] exp_strobes(input logic [3:0] st, input logic rdy);
      case (st)
         4'd0:    return rdy ? 16'h9410 : 16'h1010;
         4'd1:    return 16'h0030;
         4'd2:    return 16'h0060;
         4'd3:    return 16'h3000;
         4'd4:    return 16'h0280;
         4'd5:    return 16'h2800;
         4'd6:    return 16'h0048;
         4'd7:    return 16'h0180;
         4'd8:    return 16'h4045;
         4'd9:    return 16'h8002;
         4'd10:   return 16'h0060;
         4'd11:   return 16'h0080;
         default: return 16'h0000;
      endcase
   endfunction

   // Drive one cycle of inputs just after the rising edge and queue what the
   // DUT must show during that cycle
   task automatic step(input logic [3:0] st, input logic rdy, input logic [5:0] op,
                       input logic rst);
      exp_t x;
      @(posedge clk);
      #1;
      reset     = rst;
      mem_ready = rdy;
      opcode    = op;
      zero      = step_id[0];
      x.id  = step_id;
      x.st  = rst ? 4'd0 : st;
      x.stb = rst ? 16'h0000 : exp_strobes(st, rdy);
      x.hlt = !rst && (st == 4'd15);
      x.tc  = exp_tc;
      x.cnt = exp_cnt;
      q.push_back(x);
      step_id++;
   endtask

   // Monitor: compare one queued expectation per cycle on the falling edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (state_o !== e.st || act_stb !== e.stb || halted !== e.hlt ||
             trap_cause !== e.tc || instr_count !== e.cnt) begin
            errors++;
            $display("FAIL step%0d: got state_o=%0d strobes=%h halted=%b cause=%0d count=%0d, want state_o=%0d strobes=%h halted=%b cause=%0d count=%0d",
                     e.id, state_o, act_stb, halted, trap_cause, instr_count,
                     e.st, e.stb, e.hlt, e.tc, e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      step_id   = 0;
      exp_tc    = 2'd0;
      exp_cnt   = 32'd0;
      reset     = 1'b1;
      mem_ready = 1'b1;
      opcode    = 6'b000000;
      zero      = 1'b0;

      // Reset held three cycles
      repeat (3) step(4'd0, 1'b1, 6'b000000, 1'b1);

      // R-type: 0,1,6,7
      step(4'd0, 1'b1, 6'b000000, 1'b0);
      step(4'd1, 1'b1, 6'b000000, 1'b0);
      step(4'd6, 1'b1, 6'b000000, 1'b0);
      step(4'd7, 1'b1, 6'b000000, 1'b0);
      exp_cnt = 32'd1;

      // lw with two wait cycles in MEM_READ: 0,1,2,3,3,3,4
      step(4'd0, 1'b1, 6'b100011, 1'b0);
      step(4'd1, 1'b1, 6'b100011, 1'b0);
      step(4'd2, 1'b1, 6'b100011, 1'b0);
      step(4'd3, 1'b0, 6'b100011, 1'b0);
      step(4'd3, 1'b0, 6'b100011, 1'b0);
      step(4'd3, 1'b1, 6'b100011, 1'b0);
      step(4'd4, 1'b1, 6'b100011, 1'b0);
      exp_cnt = 32'd2;

      // sw: 0,1,2,5
      step(4'd0, 1'b1, 6'b101011, 1'b0);
      step(4'd1, 1'b1, 6'b101011, 1'b0);
      step(4'd2, 1'b1, 6'b101011, 1'b0);
      step(4'd5, 1'b1, 6'b101011, 1'b0);
      exp_cnt = 32'd3;

      // beq: 0,1,8
      step(4'd0, 1'b1, 6'b000100, 1'b0);
      step(4'd1, 1'b1, 6'b000100, 1'b0);
      step(4'd8, 1'b1, 6'b000100, 1'b0);
      exp_cnt = 32'd4;

      // j with one fetch wait cycle: 0,0,1,9
      step(4'd0, 1'b0, 6'b000010, 1'b0);
      step(4'd0, 1'b1, 6'b000010, 1'b0);
      step(4'd1, 1'b1, 6'b000010, 1'b0);
      step(4'd9, 1'b1, 6'b000010, 1'b0);
      exp_cnt = 32'd5;

      // addi: 0,1,10,11
      step(4'd0,  1'b1, 6'b001000, 1'b0);
      step(4'd1,  1'b1, 6'b001000, 1'b0);
      step(4'd10, 1'b1, 6'b001000, 1'b0);
      step(4'd11, 1'b1, 6'b001000, 1'b0);
      exp_cnt = 32'd6;

      // Illegal opcode: trap and stay silent for 20 cycles
      step(4'd0, 1'b1, 6'b111111, 1'b0);
      step(4'd1, 1'b1, 6'b111111, 1'b0);
      exp_tc = 2'b01;
      for (int i = 0; i < 20; i++)
         step(4'd15, 1'($urandom_range(0, 1)), 6'b111111, 1'b0);

      // Reset out of TRAP; cause and count clear at the edge
      step(4'd0, 1'b1, 6'b000000, 1'b1);
      exp_tc  = 2'b00;
      exp_cnt = 32'd0;

      // Fetch timeout: 15 cycles waiting, then TRAP with cause 10
      for (int i = 0; i < 15; i++)
         step(4'd0, 1'b0, 6'b000000, 1'b0);
      exp_tc = 2'b10;
      for (int i = 0; i < 3; i++)
         step(4'd15, 1'b0, 6'b000000, 1'b0);
      step(4'd0, 1'b1, 6'b000000, 1'b1);
      exp_tc = 2'b00;

      // One R-type so the counter is non-zero, then reset during MEM_WRITE
      step(4'd0, 1'b1, 6'b000000, 1'b0);
      step(4'd1, 1'b1, 6'b000000, 1'b0);
      step(4'd6, 1'b1, 6'b000000, 1'b0);
      step(4'd7, 1'b1, 6'b000000, 1'b0);
      exp_cnt = 32'd1;
      step(4'd0, 1'b1, 6'b101011, 1'b0);
      step(4'd1, 1'b1, 6'b101011, 1'b0);
      step(4'd2, 1'b1, 6'b101011, 1'b0);
      step(4'd5, 1'b1, 6'b101011, 1'b1);
      exp_cnt = 32'd0;

      // Restart cleanly from FETCH
      step(4'd0, 1'b1, 6'b000000, 1'b0);
      step(4'd1, 1'b1, 6'b000000, 1'b0);
      step(4'd6, 1'b1, 6'b000000, 1'b0);
      step(4'd7, 1'b1, 6'b000000, 1'b0);
      exp_cnt = 32'd1;
      step(4'd0, 1'b0, 6'b000000, 1'b0);

      // Let the monitor drain the queue
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
